// File: rtl/keypad_pkg.sv
// Shared definitions for the Pmod KYPD scanner: port addresses, key code table,
// status bit positions and key FSM encoding.
package keypad_pkg;

  localparam logic [7:0] PORT_STATUS_DEFAULT = 8'h04;
  localparam logic [7:0] PORT_KEY_DEFAULT    = 8'h05;

  localparam int unsigned STAT_KEY_VALID = 0;
  localparam int unsigned STAT_OVERRUN   = 1;
  localparam int unsigned STAT_MULTI     = 2;

  // Indexed by 4*column + row; entry 0 is the rightmost nibble.
  localparam logic [15:0][3:0] KEY_CODES = {
    4'hD, 4'hC, 4'hB, 4'hA,
    4'hE, 4'h9, 4'h6, 4'h3,
    4'hF, 4'h8, 4'h5, 4'h2,
    4'h0, 4'h7, 4'h4, 4'h1
  };

  typedef enum logic [0:0] {
    StIdle,
    StPressed
  } key_state_e;

  function automatic logic [3:0] lowest_set(input logic [15:0] map);
    lowest_set = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (map[i]) lowest_set = 4'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column scanner: synchronizes row returns, drives one column at a time and
// assembles a 16-bit pressed-key snapshot, pulsing scan_done once per full scan.
module keypad_col_scan #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk_d,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] snapshot,
  output logic        scan_done
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

  logic [3:0]      row_meta_q, row_sync_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [15:0]     snap_q, snap_d;
  logic            done_q, done_d;
  logic            term;

  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      div_q      <= '0;
      col_idx_q  <= 2'd0;
      snap_q     <= 16'h0000;
      done_q     <= 1'b0;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
      div_q      <= div_d;
      col_idx_q  <= col_idx_d;
      snap_q     <= snap_d;
      done_q     <= done_d;
    end
  end

  // Snapshot holds pressed=1; rows are active low on the wire.
  always_comb begin
    term      = (div_q == DivLast);
    div_d     = term ? '0 : div_q + DivW'(1);
    col_idx_d = col_idx_q;
    snap_d    = snap_q;
    done_d    = 1'b0;
    if (term) begin
      snap_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
      col_idx_d = col_idx_q + 2'd1;
      done_d    = (col_idx_q == 2'd3);
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign snapshot  = snap_q;
  assign scan_done = done_q;

endmodule

// File: rtl/keypad_scanner_pb.sv
// PicoBlaze input-port keypad scanner: debounces full-matrix snapshots, captures
// one key code per press and serves status/key bytes through the INPUT port.
module keypad_scanner_pb
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter logic [7:0]  PORT_STATUS    = PORT_STATUS_DEFAULT,
  parameter logic [7:0]  PORT_KEY       = PORT_KEY_DEFAULT
) (
  input  logic       clk_d,
  input  logic       reset,
  input  logic [7:0] id_port,
  input  logic       rd_reg,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  localparam logic [3:0] MatchLast = 4'(DEBOUNCE_SCANS - 1);

  logic [15:0] snapshot;
  logic        scan_done;

  keypad_col_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_col_scan (
    .clk_d    (clk_d),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .snapshot (snapshot),
    .scan_done(scan_done)
  );

  logic [15:0] prev_snap_q, prev_snap_d;
  logic [15:0] debounced_q, debounced_d;
  logic [3:0]  match_cnt_q, match_cnt_d;
  key_state_e  state_q, state_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        overrun_q, overrun_d;
  logic        interrupt_q, interrupt_d;
  logic [7:0]  in_port_q, in_port_d;
  logic        multi, capture, key_read;
  logic [7:0]  status;

  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      prev_snap_q <= 16'h0000;
      debounced_q <= 16'h0000;
      match_cnt_q <= 4'd0;
      state_q     <= StIdle;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      interrupt_q <= 1'b0;
      in_port_q   <= 8'h00;
    end else begin
      prev_snap_q <= prev_snap_d;
      debounced_q <= debounced_d;
      match_cnt_q <= match_cnt_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
      interrupt_q <= interrupt_d;
      in_port_q   <= in_port_d;
    end
  end

  // Debounce: the map only moves after enough identical consecutive scans.
  always_comb begin
    prev_snap_d = prev_snap_q;
    match_cnt_d = match_cnt_q;
    debounced_d = debounced_q;
    if (scan_done) begin
      prev_snap_d = snapshot;
      if (snapshot == prev_snap_q) begin
        match_cnt_d = (match_cnt_q == MatchLast) ? match_cnt_q : match_cnt_q + 4'd1;
      end else begin
        match_cnt_d = 4'd0;
      end
      if (match_cnt_d == MatchLast) debounced_d = snapshot;
    end
  end

  assign multi = |(debounced_q & (debounced_q - 16'd1));

  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    interrupt_d = interrupt_q;
    key_read    = rd_reg && (id_port == PORT_KEY);

    unique case (state_q)
      StIdle: begin
        if (|debounced_q) begin
          state_d = StPressed;
          capture = 1'b1;
        end
      end
      StPressed: begin
        if (~|debounced_q) state_d = StIdle;
      end
    endcase

    if (key_read) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (interrupt_ack) interrupt_d = 1'b0;

    // A coincident read consumes the old key, so it is not an overrun.
    if (capture) begin
      key_code_d  = KEY_CODES[lowest_set(debounced_q)];
      key_valid_d = 1'b1;
      overrun_d   = key_valid_q && !key_read;
      interrupt_d = 1'b1;
    end
  end

  always_comb begin
    status                 = 8'h00;
    status[STAT_KEY_VALID] = key_valid_q;
    status[STAT_OVERRUN]   = overrun_q;
    status[STAT_MULTI]     = multi;
    if (id_port == PORT_STATUS) begin
      in_port_d = status;
    end else if (id_port == PORT_KEY) begin
      in_port_d = {4'h0, key_code_q};
    end else begin
      in_port_d = 8'h00;
    end
  end

  assign in_port   = in_port_q;
  assign interrupt = interrupt_q;

endmodule

// File: tb/tb_keypad_scanner_pb.sv
// Directed bench for keypad_scanner_pb: a keypad model answers the column drive,
// reads push expected bytes into a scoreboard that a monitor drains.
module tb_keypad_scanner_pb;

  localparam logic [7:0] P_STAT = 8'h04;
  localparam logic [7:0] P_KEY  = 8'h05;

  logic       clk_d = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] id_port = 8'h00;
  logic       rd_reg = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;
  logic [15:0] key_map = 16'h0000;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;
  exp_t sb[$];
  logic rd_dly = 1'b0;

  always #5 clk_d = ~clk_d;

  // Keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) row = row & ~key_map[4*c +: 4];
    end
  end

  keypad_scanner_pb #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2),
    .PORT_STATUS   (P_STAT),
    .PORT_KEY      (P_KEY)
  ) dut (
    .clk_d        (clk_d),
    .reset        (reset),
    .id_port      (id_port),
    .rd_reg       (rd_reg),
    .row          (row),
    .col          (col),
    .in_port      (in_port),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack)
  );

  always @(posedge clk_d) rd_dly <= rd_reg;

  always @(negedge clk_d) begin : monitor
    exp_t e;
    if (rd_dly) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_read: in_port=%02h required no read", in_port);
      end else begin
        e = sb.pop_front();
        if (in_port !== e.exp) begin
          miscompares++;
          $display("FAIL %s: in_port=%02h required %02h", e.name, in_port, e.exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_d);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h required %02h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [7:0] port, input logic [7:0] exp, input string nm);
    id_port = port;
    rd_reg  = 1'b1;
    sb.push_back('{exp: exp, name: nm});
    @(negedge clk_d);
    rd_reg  = 1'b0;
    id_port = 8'h00;
  endtask

  task automatic wait_irq(input int budget, input string nm);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_d);
      if (interrupt === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL %s: interrupt=0 after %0d cycles required 1", nm, budget);
    end
  endtask

  task automatic ack(input string nm);
    interrupt_ack = 1'b1;
    @(negedge clk_d);
    interrupt_ack = 1'b0;
    chk(nm, {7'h0, interrupt}, 8'h00);
  endtask

  initial begin
    // Reset asserted mid-scan.
    tick(3);
    reset = 1'b0;
    tick(6);
    #2 reset = 1'b1;
    #1;
    chk("rst_col", {4'h0, col}, 8'h0E);
    chk("rst_in_port", in_port, 8'h00);
    chk("rst_irq", {7'h0, interrupt}, 8'h00);
    tick(2);

    // Key "1" from reset release.
    reset   = 1'b0;
    key_map = 16'h0001;
    wait_irq(48, "irq_key1");
    rd(P_STAT, 8'h01, "status_key1");
    rd(P_KEY, 8'h01, "code_key1");
    rd(P_STAT, 8'h00, "status_after_read");
    ack("ack_key1");
    key_map = 16'h0000;
    tick(64);

    // 10-cycle glitch on "5".
    key_map = 16'h0020;
    tick(10);
    key_map = 16'h0000;
    tick(64);
    chk("glitch_irq", {7'h0, interrupt}, 8'h00);
    rd(P_STAT, 8'h00, "glitch_status");

    // "A" then "D" unread: overrun.
    key_map = 16'h1000;
    wait_irq(64, "irq_A");
    ack("ack_A");
    key_map = 16'h0000;
    tick(64);
    key_map = 16'h8000;
    wait_irq(64, "irq_D");
    rd(P_STAT, 8'h03, "status_overrun");
    rd(P_KEY, 8'h0D, "code_D");
    rd(P_STAT, 8'h00, "status_cleared");
    ack("ack_D");
    key_map = 16'h0000;
    tick(64);

    // "2" and "F" together.
    key_map = 16'h0090;
    wait_irq(64, "irq_2F");
    rd(P_STAT, 8'h05, "status_multi");
    rd(P_KEY, 8'h02, "code_2F");
    ack("ack_2F");
    key_map = 16'h0010;
    tick(64);
    chk("no_recapture_irq", {7'h0, interrupt}, 8'h00);
    rd(P_STAT, 8'h00, "no_recapture_status");
    rd(P_KEY, 8'h02, "no_recapture_code");
    key_map = 16'h0000;
    tick(64);

    // Capture coincident with a PORT_KEY read and an interrupt_ack.
    reset = 1'b1;
    tick(2);
    reset   = 1'b0;
    key_map = 16'h0001;
    tick(33);
    chk("pre_capture_irq", {7'h0, interrupt}, 8'h00);
    id_port       = P_KEY;
    rd_reg        = 1'b1;
    interrupt_ack = 1'b1;
    sb.push_back('{exp: 8'h00, name: "code_before_capture"});
    @(negedge clk_d);
    rd_reg        = 1'b0;
    interrupt_ack = 1'b0;
    chk("capture_beats_ack", {7'h0, interrupt}, 8'h01);
    rd(P_STAT, 8'h01, "capture_beats_read");
    rd(P_KEY, 8'h01, "code_after_capture");
    tick(3);
    chk("irq_held", {7'h0, interrupt}, 8'h01);

    // Reset mid-press; the held key is reported again.
    id_port = P_KEY;
    tick(5);
    #2 reset = 1'b1;
    #1;
    chk("rst_press_col", {4'h0, col}, 8'h0E);
    chk("rst_press_in_port", in_port, 8'h00);
    chk("rst_press_irq", {7'h0, interrupt}, 8'h00);
    tick(1);
    id_port = 8'h00;
    reset   = 1'b0;
    wait_irq(48, "irq_after_reset");
    rd(P_KEY, 8'h01, "code_after_reset");
    key_map = 16'h0000;
    tick(4);
    chk("scoreboard_drained", 8'(sb.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner_pb.md
Name: keypad_scanner_pb

Overview:
- PicoBlaze input-port peripheral that scans the 4x4 Pmod KYPD matrix by time-multiplexing its columns.
- Debounces the row returns and latches one hex key code per press.
- The processor reads status and key code through the INPUT port strobe/address interface.
- Companion of the display encoder: that block is a written output port that multiplexes digits out; this block multiplexes keys in and is read.

Parameters:
- SCAN_DIV, 100000: clk_d cycles each column is driven (1 ms at 100 MHz).
- DEBOUNCE_SCANS, 4: consecutive identical full-matrix snapshots required before the debounced map updates; legal range 2..15.
- PORT_STATUS, 8'h04: id_port value that selects the status byte.
- PORT_KEY, 8'h05: id_port value that selects the key byte.

Ports:
- clk_d  input  1  system clock; one clock domain.
- reset  input  1  asynchronous, active-high reset.
- id_port  input  8  PicoBlaze port address.
- rd_reg  input  1  PicoBlaze read_strobe.
- row  input  4  keypad row returns, active low, asynchronous to clk_d.
- col  output  4  keypad column drive, one-hot active low.
- in_port  output  8  registered read data to PicoBlaze.
- interrupt  output  1  key-available interrupt request.
- interrupt_ack  input  1  PicoBlaze interrupt acknowledge.

Behaviour:
- Reset values: col=4'b1110, in_port=8'h00, interrupt=0. Internally: column index 0, divider 0, snapshot and debounced map all-released, key_valid=0, overrun=0, multi=0, key_code=0, FSM=IDLE.
- Reset is asserted mid-scan or mid-press: all state clears immediately. A key still held after reset is reported again once it has debounced.
- row passes through a 2-FF synchronizer, so sampling sees the value from 2 cycles earlier.
- Divider counts 0..SCAN_DIV-1.
  - On its terminal count, the synchronized row is stored into snapshot bits [4*c+3:4*c], where c is the current column index.
  - On the same cycle the column index increments, wrapping 3->0, and col rotates through 1110, 1101, 1011, 0111.
- After column 3 is sampled, one full scan is complete.
  - If the new snapshot equals the previous one, the match counter increments, saturating. Otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_SCANS-1, the debounced map takes the snapshot.
- Key index is the lowest set (pressed) bit of the debounced map. multi=1 when more than one bit is pressed.
- key_code comes from the table: index 0..15 maps to 1,4,7,0, 2,5,8,F, 3,6,9,E, A,B,C,D (col-major, row 0 first).
- Key FSM:
  - IDLE -> PRESSED when the debounced map becomes non-empty. On this transition: key_code is latched, key_valid<=1, interrupt<=1, overrun<=key_valid_old.
  - PRESSED -> IDLE when the debounced map becomes all released.
  - Changes in which keys are held while in PRESSED do not generate a new key.
- Read path: in_port is registered each cycle.
  - PORT_STATUS -> {5'b0, multi, overrun, key_valid}.
  - PORT_KEY -> {4'b0, key_code}.
  - Any other address -> 8'h00.
- rd_reg=1 with id_port=PORT_KEY clears key_valid and overrun on the next edge.
- If a key capture coincides with a PORT_KEY read, the capture wins: key_valid stays 1, overrun stays 0, key_code takes the new value.
- Reading PORT_STATUS has no side effects.
- interrupt_ack clears interrupt on the next edge. If ack and a capture coincide, interrupt stays 1.

Decomposition:
- Shared package keypad_pkg holds:
  - default port addresses;
  - the 16-entry key code table;
  - status bit positions (KEY_VALID=0, OVERRUN=1, MULTI=2);
  - FSM state encoding.
- Sub-module keypad_col_scan holds the synchronizer, divider, column rotation and snapshot assembly, with output snapshot plus a scan_done pulse.
- Debounce, FSM and the read mux stay in the top module.

Test Plan:
- Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=2, so one scan is 16 cycles.
- Assert reset mid-scan -> col=4'b1110, in_port=8'h00, interrupt=0 in the same cycle.
- Hold row0 low only while col=4'b1110 (key "1") -> within 48 cycles key_valid=1 and interrupt=1. Reading PORT_KEY gives in_port=8'h01; key_valid=0 afterwards.
- 10-cycle row glitch on key "5" -> key_valid never sets, in_port on PORT_STATUS stays 8'h00.
- Press and release "A", then press "D" without reading -> PORT_STATUS=8'h03 and PORT_KEY=8'h0D; the read clears status to 8'h00.
- Hold "2" and "F" together -> key_code=8'h02, status=8'h05. No second capture occurs until both are released.
- Capture coincides with a PORT_KEY read, and interrupt_ack coincides with capture -> key_valid=1, overrun=0, interrupt remains 1.
